// File: rtl/instruction_fetch_unit.sv
// IF stage with IF/ID pipeline register: owns the PC, issues single-outstanding
// fetches to instruction memory, and applies decode stall and redirect.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        ID_stall,
   input  logic        ID_PCSrc,
   input  logic [31:0] ID_new_PC,
   output logic        IM_Req,
   output logic [31:0] IM_Addr,
   input  logic        IM_Ready,
   input  logic [31:0] IM_RData,
   output logic [31:0] IF_ID_Instruction,
   output logic [31:0] IF_ID_PC4,
   output logic        IF_ID_Valid,
   output logic [31:0] IF_PC
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_DROP  = 2'd1,
      S_HOLD  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] bufpc4_q, bufpc4_d;
   logic [31:0] redir_q, redir_d;

   logic        redirect;
   logic [31:0] pc_plus4;

   assign redirect = ID_PCSrc & ~ID_stall;
   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      pc4_d    = pc4_q;
      valid_d  = valid_q;
      buf_d    = buf_q;
      bufpc4_d = bufpc4_q;
      redir_d  = redir_q;

      case (state_q)
         S_FETCH: begin
            if (IM_Ready) begin
               if (redirect) begin
                  pc_d    = ID_new_PC;
                  instr_d = NOP_INSTR;
                  pc4_d   = '0;
                  valid_d = 1'b0;
               end else if (ID_stall) begin
                  // Accept the word now so the memory is free; park it until decode drains.
                  buf_d    = IM_RData;
                  bufpc4_d = pc_plus4;
                  pc_d     = pc_plus4;
                  state_d  = S_HOLD;
               end else begin
                  instr_d = IM_RData;
                  pc4_d   = pc_plus4;
                  valid_d = 1'b1;
                  pc_d    = pc_plus4;
               end
            end else if (redirect) begin
               redir_d = ID_new_PC;
               instr_d = NOP_INSTR;
               pc4_d   = '0;
               valid_d = 1'b0;
               state_d = S_DROP;
            end else if (!ID_stall) begin
               instr_d = NOP_INSTR;
               pc4_d   = '0;
               valid_d = 1'b0;
            end
         end

         S_DROP: begin
            if (redirect) redir_d = ID_new_PC;
            if (!ID_stall) begin
               instr_d = NOP_INSTR;
               pc4_d   = '0;
               valid_d = 1'b0;
            end
            if (IM_Ready) begin
               pc_d    = redirect ? ID_new_PC : redir_q;
               state_d = S_FETCH;
            end
         end

         S_HOLD: begin
            if (!ID_stall) begin
               if (ID_PCSrc) begin
                  pc_d    = ID_new_PC;
                  instr_d = NOP_INSTR;
                  pc4_d   = '0;
                  valid_d = 1'b0;
               end else begin
                  instr_d = buf_q;
                  pc4_d   = bufpc4_q;
                  valid_d = 1'b1;
               end
               state_d = S_FETCH;
            end
         end

         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         instr_q  <= NOP_INSTR;
         pc4_q    <= '0;
         valid_q  <= 1'b0;
         buf_q    <= '0;
         bufpc4_q <= '0;
         redir_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pc4_q    <= pc4_d;
         valid_q  <= valid_d;
         buf_q    <= buf_d;
         bufpc4_q <= bufpc4_d;
         redir_q  <= redir_d;
      end
   end

   assign IM_Req            = (state_q != S_HOLD);
   assign IM_Addr           = pc_q;
   assign IF_ID_Instruction = instr_q;
   assign IF_ID_PC4         = pc4_q;
   assign IF_ID_Valid       = valid_q;
   assign IF_PC             = pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: memory returns address ^ KEY so
// every delivered word identifies the address it came from.
module tb_instruction_fetch_unit;

   localparam logic [31:0] KEY = 32'h1357_9BDF;
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        pcsrc;
   logic [31:0] new_pc;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ready;
   logic [31:0] im_rdata;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic [31:0] if_pc;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   assign im_rdata = im_ready ? (im_addr ^ KEY) : 32'hDEAD_BEEF;

   instruction_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .NOP_INSTR(32'h0000_0000)
   ) dut (
      .Clk              (clk),
      .Reset            (rst),
      .ID_stall         (stall),
      .ID_PCSrc         (pcsrc),
      .ID_new_PC        (new_pc),
      .IM_Req           (im_req),
      .IM_Addr          (im_addr),
      .IM_Ready         (im_ready),
      .IM_RData         (im_rdata),
      .IF_ID_Instruction(ifid_instr),
      .IF_ID_PC4        (ifid_pc4),
      .IF_ID_Valid      (ifid_valid),
      .IF_PC            (if_pc)
   );

   function automatic logic [31:0] w(input logic [31:0] a);
      return a ^ KEY;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] ins,
                           input logic [31:0] pc4, input logic v);
      check({tag, ".instr"}, ifid_instr, ins);
      check({tag, ".pc4"},   ifid_pc4,   pc4);
      check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; pcsrc = 1'b0; new_pc = '0; im_ready = 1'b1;
      tick(); tick();
      check("rst.addr", im_addr, 32'h0);
      check("rst.req", {31'd0, im_req}, 32'd1);
      check("rst.pc", if_pc, 32'h0);
      chk_ifid("rst", NOP, 32'h0, 1'b0);

      // Zero-wait streaming
      rst = 1'b0;
      tick();
      check("zw0.addr", im_addr, 32'h4);
      chk_ifid("zw0", w(32'h0), 32'h4, 1'b1);
      tick();
      check("zw1.addr", im_addr, 32'h8);
      chk_ifid("zw1", w(32'h4), 32'h8, 1'b1);
      tick(); tick();
      check("zw3.addr", im_addr, 32'h10);
      chk_ifid("zw3", w(32'hC), 32'h10, 1'b1);

      // Redirect at PC=0x10 to 0x40
      pcsrc = 1'b1; new_pc = 32'h40;
      tick();
      pcsrc = 1'b0;
      check("rd.addr", im_addr, 32'h40);
      chk_ifid("rd.bubble", NOP, 32'h0, 1'b0);
      tick();
      check("rd1.addr", im_addr, 32'h44);
      chk_ifid("rd1", w(32'h40), 32'h44, 1'b1);

      // Stall 3 cycles with memory ready
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("st.req", {31'd0, im_req}, 32'd0);
         check("st.pc", if_pc, 32'h48);
         chk_ifid("st.held", w(32'h40), 32'h44, 1'b1);
      end
      stall = 1'b0;
      tick();
      check("st.rel.addr", im_addr, 32'h48);
      check("st.rel.req", {31'd0, im_req}, 32'd1);
      chk_ifid("st.rel", w(32'h44), 32'h48, 1'b1);
      tick();
      chk_ifid("st.next", w(32'h48), 32'h4C, 1'b1);

      // 3-cycle wait, redirect to 0x80 in first wait cycle
      im_ready = 1'b0; pcsrc = 1'b1; new_pc = 32'h80;
      tick();
      pcsrc = 1'b0;
      check("wt1.addr", im_addr, 32'h4C);
      check("wt1.req", {31'd0, im_req}, 32'd1);
      chk_ifid("wt1", NOP, 32'h0, 1'b0);
      tick();
      check("wt2.addr", im_addr, 32'h4C);
      chk_ifid("wt2", NOP, 32'h0, 1'b0);
      im_ready = 1'b1;
      tick();
      check("wt3.addr", im_addr, 32'h80);
      chk_ifid("wt3.drop", NOP, 32'h0, 1'b0);
      tick();
      check("wt4.addr", im_addr, 32'h84);
      chk_ifid("wt4", w(32'h80), 32'h84, 1'b1);

      // HOLD, then release with a pending redirect to 0x200
      stall = 1'b1;
      tick();
      check("hr.req", {31'd0, im_req}, 32'd0);
      pcsrc = 1'b1; new_pc = 32'h200;
      tick();
      check("hr.pc", if_pc, 32'h88);
      chk_ifid("hr.held", w(32'h80), 32'h84, 1'b1);
      stall = 1'b0;
      tick();
      pcsrc = 1'b0;
      check("hr.addr", im_addr, 32'h200);
      check("hr.req1", {31'd0, im_req}, 32'd1);
      chk_ifid("hr.bubble", NOP, 32'h0, 1'b0);
      tick();
      chk_ifid("hr.next", w(32'h200), 32'h204, 1'b1);

      // PC wrap at the top of the address space
      pcsrc = 1'b1; new_pc = 32'hFFFF_FFFC;
      tick();
      pcsrc = 1'b0;
      check("wr.addr", im_addr, 32'hFFFF_FFFC);
      tick();
      check("wr.pc", if_pc, 32'h0);
      chk_ifid("wr", w(32'hFFFF_FFFC), 32'h0, 1'b1);
      tick();
      check("wr2.addr", im_addr, 32'h4);

      // Wait without redirect gives a bubble, then reset mid-wait
      im_ready = 1'b0;
      tick();
      check("mw.addr", im_addr, 32'h4);
      chk_ifid("mw", NOP, 32'h0, 1'b0);
      rst = 1'b1;
      tick();
      check("mr.addr", im_addr, 32'h0);
      check("mr.req", {31'd0, im_req}, 32'd1);
      chk_ifid("mr", NOP, 32'h0, 1'b0);
      rst = 1'b0; im_ready = 1'b1;
      tick();
      chk_ifid("mr.next", w(32'h0), 32'h4, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
